// File: rtl/direction_queue.sv
// direction_queue
//   Merges four debounced direction buttons and decoded bluetooth command
//   bytes into a single registered heading for the snake datapath. Null and
//   180-degree turns are filtered, and up to FIFO_DEPTH pending turns are
//   buffered. One turn is released per snake step.
//
// Ports
//   clk, rst              system clock, async active-high reset
//   right/down/left/up    raw buttons, asynchronous to clk
//   bt_data, bt_valid     received bluetooth byte + one-cycle strobe
//   step_tick             one-cycle strobe per snake move (pops a turn)
//   game_active           high while in GAME; low flushes and forces INIT_DIR
//   dir                   current heading (00 right, 01 down, 10 left, 11 up)
//   pending               queued-turn count, 0..FIFO_DEPTH
//   overflow              one-cycle pulse after a valid turn hit a full queue

// Per-button synchroniser + debouncer. press pulses for one cycle, registered
// at the same edge the stable level rises.
module dq_debounce #(
  parameter int CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(CYCLES + 1);

  logic          sync0, sync1, stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      press <= 1'b0;
      if (sync1 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        // this edge is the CYCLES-th consecutive differing sample
        cnt    <= '0;
        stable <= sync1;
        press  <= sync1;   // only the 0->1 transition is an event
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module direction_queue #(
  parameter int         DEBOUNCE_CYCLES = 1000000,
  parameter int         FIFO_DEPTH      = 4,
  parameter logic [1:0] INIT_DIR        = 2'b00
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          right,
  input  logic                          down,
  input  logic                          left,
  input  logic                          up,
  input  logic [7:0]                    bt_data,
  input  logic                          bt_valid,
  input  logic                          step_tick,
  input  logic                          game_active,
  output logic [1:0]                    dir,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  // Button index equals its direction code, so lowest index = highest priority.
  logic [3:0] raw_btn;
  logic [3:0] btn_press;
  assign raw_btn = {up, left, down, right};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    dq_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_btn[i]),
      .press (btn_press[i])
    );
  end

  // Bluetooth command decode
  logic       bt_hit;
  logic [1:0] bt_dir;
  always_comb begin
    bt_hit = 1'b0;
    bt_dir = 2'b00;
    if (bt_valid) begin
      case (bt_data)
        8'h4B:   begin bt_hit = 1'b1; bt_dir = 2'b00; end
        8'h4A:   begin bt_hit = 1'b1; bt_dir = 2'b01; end
        8'h48:   begin bt_hit = 1'b1; bt_dir = 2'b10; end
        8'h55:   begin bt_hit = 1'b1; bt_dir = 2'b11; end
        default: ;
      endcase
    end
  end

  // Arbitration: scan downwards so the lowest-index button overrides.
  logic       ev;
  logic [1:0] cand;
  always_comb begin
    ev   = (|btn_press) | bt_hit;
    cand = bt_dir;
    for (int i = 3; i >= 0; i--)
      if (btn_press[i]) cand = 2'(i);
  end

  // Queue storage
  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [1:0]    tail;
  logic          accept, full, pop, push, ovf_next;

  // Filter against the heading the snake will have once everything queued
  // has been applied.
  assign tail     = (pending != '0) ? mem[wr_ptr - 1'b1] : dir;
  assign accept   = game_active && ev && (cand != tail) && (cand != (tail ^ 2'b10));
  assign full     = (pending == DEPTH);
  assign pop      = game_active && step_tick && (pending != '0);
  // A pop frees the slot this edge, so a full queue still takes a push then.
  assign push     = accept && (!full || pop);
  assign ovf_next = accept && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir      <= INIT_DIR;
      pending  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else if (!game_active) begin
      dir      <= INIT_DIR;
      pending  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= ovf_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        dir    <= mem[rd_ptr];   // pre-existing head, even if full and overwritten
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by pending.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cand;
  end
endmodule

// File: tb/tb_direction_queue.sv
module tb_direction_queue;
  localparam int DB = 4;
  localparam int FD = 4;

  logic       clk = 1'b0, rst = 1'b1;
  logic       right = 1'b0, down = 1'b0, left = 1'b0, up = 1'b0;
  logic [7:0] bt_data = 8'h00;
  logic       bt_valid = 1'b0, step_tick = 1'b0, game_active = 1'b1;
  logic [1:0] dir;
  logic [2:0] pending;
  logic       overflow;

  direction_queue #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(FD), .INIT_DIR(2'b00)) dut (
    .clk(clk), .rst(rst), .right(right), .down(down), .left(left), .up(up),
    .bt_data(bt_data), .bt_valid(bt_valid), .step_tick(step_tick),
    .game_active(game_active), .dir(dir), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Scoreboard: each entry is the next output state the DUT must present,
  // optionally pinned to an exact cycle (ec < 0 = any cycle).
  typedef struct {
    string      name;
    logic [1:0] d;
    logic [2:0] p;
    logic       o;
    int         ec;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0, errors = 0;
  bit         mon_en = 1'b0, have_last = 1'b0;
  logic [5:0] last;

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic exp_push(string nm, logic [1:0] d, logic [2:0] p, logic o, int ec);
    exp_t e;
    e.name = nm; e.d = d; e.p = p; e.o = o; e.ec = ec;
    sb.push_back(e);
  endtask

  task automatic bt_send(logic [7:0] b);
    bt_data = b; bt_valid = 1'b1;
    tick();
    bt_valid = 1'b0; bt_data = 8'h00;
  endtask

  task automatic step();
    step_tick = 1'b1;
    tick();
    step_tick = 1'b0;
  endtask

  // Monitor: every change of the output state consumes one scoreboard entry.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [5:0] cur;
      exp_t e;
      cur = {dir, pending, overflow};
      if (!have_last || cur != last) begin
        have_last = 1'b1;
        last = cur;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: dir=%b pending=%0d overflow=%b at cycle %0d, required no change",
                   dir, pending, overflow, cyc);
        end else begin
          e = sb.pop_front();
          if (dir !== e.d || pending !== e.p || overflow !== e.o || (e.ec >= 0 && cyc != e.ec)) begin
            errors++;
            $display("FAIL %s: got dir=%b pending=%0d overflow=%b cycle=%0d, required dir=%b pending=%0d overflow=%b cycle=%0d",
                     e.name, dir, pending, overflow, cyc, e.d, e.p, e.o, e.ec);
          end
        end
      end
    end
  end

  initial begin
    int c0;
    exp_push("reset", 2'b00, 3'd0, 1'b0, -1);
    mon_en = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);

    // T1: clean hold of up, event lands DB+3 cycles after the raw rise
    c0 = cyc; up = 1'b1;
    exp_push("t1_up_latency", 2'b00, 3'd1, 1'b0, c0 + 7);
    tick(10); up = 1'b0; tick(8);
    exp_push("t1_step", 2'b11, 3'd0, 1'b0, cyc + 1);
    step(); tick(2);

    // T2: 3-cycle pulse is too short; 1-0-1 bounce then hold gives one event
    right = 1'b1; tick(3); right = 1'b0; tick(10);
    right = 1'b1; tick(); right = 1'b0; tick();
    c0 = cyc; right = 1'b1;
    exp_push("t2_bounce", 2'b11, 3'd1, 1'b0, c0 + 7);
    tick(12); right = 1'b0; tick(8);
    exp_push("t2_step", 2'b00, 3'd0, 1'b0, cyc + 1);
    step(); tick(2);

    // T3: bluetooth decode and filtering (dir=00)
    bt_send(8'h48);                                     // left: reversal
    bt_send(8'h41);                                     // not a command
    exp_push("t3_bt_up", 2'b00, 3'd1, 1'b0, cyc + 1);
    bt_send(8'h55);
    bt_send(8'h4A);                                     // down: reversal of queued up
    bt_send(8'h55);                                     // up again: null turn
    tick(2);
    exp_push("t3_step", 2'b11, 3'd0, 1'b0, cyc + 1);
    step(); tick(2);

    // T4: right and up on the same cycle with dir=11, right wins
    c0 = cyc; right = 1'b1; up = 1'b1;
    exp_push("t4_right_wins", 2'b11, 3'd1, 1'b0, c0 + 7);
    tick(10); right = 1'b0; up = 1'b0; tick(8);
    exp_push("t4_step", 2'b00, 3'd0, 1'b0, cyc + 1);
    step(); tick(2);

    // T5: fill, overflow, drain in order
    exp_push("t5_fill1", 2'b00, 3'd1, 1'b0, cyc + 1); bt_send(8'h55);
    exp_push("t5_fill2", 2'b00, 3'd2, 1'b0, cyc + 1); bt_send(8'h48);
    exp_push("t5_fill3", 2'b00, 3'd3, 1'b0, cyc + 1); bt_send(8'h4A);
    exp_push("t5_fill4", 2'b00, 3'd4, 1'b0, cyc + 1); bt_send(8'h4B);
    exp_push("t5_ovf_pulse", 2'b00, 3'd4, 1'b1, cyc + 1);
    exp_push("t5_ovf_end",   2'b00, 3'd4, 1'b0, cyc + 2);
    bt_send(8'h55); tick(2);
    exp_push("t5_pop1", 2'b11, 3'd3, 1'b0, cyc + 1); step();
    exp_push("t5_pop2", 2'b10, 3'd2, 1'b0, cyc + 1); step();
    exp_push("t5_pop3", 2'b01, 3'd1, 1'b0, cyc + 1); step();
    exp_push("t5_pop4", 2'b00, 3'd0, 1'b0, cyc + 1); step();
    step(); tick(2);                                    // empty: dir holds

    // push into empty queue on a tick cycle: not applied until next tick
    bt_data = 8'h55; bt_valid = 1'b1; step_tick = 1'b1;
    exp_push("t5_empty_pushpop", 2'b00, 3'd1, 1'b0, cyc + 1);
    tick();
    bt_valid = 1'b0; bt_data = 8'h00; step_tick = 1'b0;
    exp_push("t5_next_tick", 2'b11, 3'd0, 1'b0, cyc + 1);
    step(); tick(2);

    // refill from dir=11, then push+pop while full
    exp_push("t5_refill1", 2'b11, 3'd1, 1'b0, cyc + 1); bt_send(8'h4B);
    exp_push("t5_refill2", 2'b11, 3'd2, 1'b0, cyc + 1); bt_send(8'h4A);
    exp_push("t5_refill3", 2'b11, 3'd3, 1'b0, cyc + 1); bt_send(8'h48);
    exp_push("t5_refill4", 2'b11, 3'd4, 1'b0, cyc + 1); bt_send(8'h55);
    bt_data = 8'h4B; bt_valid = 1'b1; step_tick = 1'b1;
    exp_push("t5_full_pushpop", 2'b00, 3'd4, 1'b0, cyc + 1);
    tick();
    bt_valid = 1'b0; bt_data = 8'h00; step_tick = 1'b0;
    exp_push("t5_pop_down", 2'b01, 3'd3, 1'b0, cyc + 1);
    step(); tick(2);

    // T6: game_active low flushes and forces INIT_DIR; inputs ignored
    exp_push("t6_flush", 2'b00, 3'd0, 1'b0, cyc + 1);
    game_active = 1'b0; tick();
    step(); bt_send(8'h4A); tick(3);
    game_active = 1'b1; tick(2);
    exp_push("t6_requeue", 2'b00, 3'd1, 1'b0, cyc + 1); bt_send(8'h4A);
    exp_push("t6_first_tick", 2'b01, 3'd0, 1'b0, cyc + 1); step(); tick(2);

    // async reset mid-debounce: outputs reset within the same cycle
    left = 1'b1; tick(3);
    exp_push("t6_async_rst", 2'b00, 3'd0, 1'b0, cyc);
    rst = 1'b1; left = 1'b0;
    tick(2); rst = 1'b0; tick(15);

    // every expected state must have been presented
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left (next %s), required 0", sb.size(), sb[0].name);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
